// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_ctrl
// Brief    : Bit-serial subtractor controller, LSB first, one bit per clock.
//            Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [c_CW-1:0]  r_cnt;
  logic             r_br;

  logic             w_accept;
  logic             w_last;
  logic             w_ai;
  logic             w_bi;
  logic             w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_work_next;

  assign w_accept    = start && (r_state != S_RUN);
  assign w_last      = (r_state == S_RUN) && (r_cnt == c_LAST);
  assign w_ai        = r_a[0];
  assign w_bi        = r_b[0];
  assign w_diff      = w_ai ^ w_bi ^ r_br;
  assign w_borrow    = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_work_next = {w_diff, r_work[WIDTH-1:1]};

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == c_LAST) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand shifters and borrow chain; results update only on the MSB cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_work <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_br   <= bin;
      r_work <= '0;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_a    <= {1'b0, r_a[WIDTH-1:1]};
      r_b    <= {1'b0, r_b[WIDTH-1:1]};
      r_br   <= w_borrow;
      r_work <= w_work_next;
      r_cnt  <= r_cnt + c_ONE;
      if (w_last) begin
        d    <= w_work_next;
        bout <= w_borrow;
`ifdef SERIAL_SUB_OVF_EN
        // r_br here is the borrow entering the MSB stage.
        ovf  <= r_br ^ w_borrow;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub_ctrl
// Brief    : Directed self-checking bench for serial_sub_ctrl (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Steps one edge at a time until done; counts edges and busy drops before done.
  task automatic wait_done(output int n, output int busy_low, output int d_moved,
                           input logic [WIDTH-1:0] d_hold);
    n = 0;
    busy_low = 0;
    d_moved = 0;
    while (!done && n < 20) begin
      if (!busy) busy_low++;
      if (d !== d_hold) d_moved++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tbin, input logic [7:0] exp_d, input logic exp_bout);
    int n, bl, dm;
    logic [WIDTH-1:0] hold;
    hold = d;
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, bl, dm, hold);
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_busy"}, bl, 0);
    chk({tag, "_dheld"}, dm, 0);
    chk({tag, "_d"}, d, exp_d);
    chk({tag, "_bout"}, bout, exp_bout);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n, bl, dm, extra;
    logic [7:0] bb_a [3];
    logic [7:0] bb_b [3];
    logic [7:0] bb_d [3];
    logic       bb_o [3];

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    chk("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("basic", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
    run_op("under", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op("binin", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);

    // Busy guard: a second request at RUN cycle 3 must be ignored.
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, bl, dm, 8'h00);
    chk("guard_latency", n + 4, 8);
    chk("guard_d", d, 8'h7F);
    chk("guard_bout", bout, 0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    chk("guard_no_second", extra, 0);

    // Back-to-back with start held high: DONE re-enters RUN directly, so results
    // arrive every WIDTH+1 edges (WIDTH RUN cycles plus the DONE cycle).
    bb_a[0] = 8'h33; bb_b[0] = 8'h11; bb_d[0] = 8'h22; bb_o[0] = 1'b0;
    bb_a[1] = 8'h01; bb_b[1] = 8'h02; bb_d[1] = 8'hFF; bb_o[1] = 1'b1;
    bb_a[2] = 8'hC8; bb_b[2] = 8'h64; bb_d[2] = 8'h64; bb_o[2] = 1'b0;
    a = bb_a[0]; b = bb_b[0]; bin = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("b2b_busy_after_accept", busy, 1);
      if (k < 2) begin
        a = bb_a[k+1]; b = bb_b[k+1];
      end else begin
        start = 1'b0;
      end
      wait_done(n, bl, dm, d);
      chk("b2b_latency", n, 8);
      chk("b2b_d", d, bb_d[k]);
      chk("b2b_bout", bout, bb_o[k]);
    end
    @(posedge clk);
    #1;
    chk("b2b_idle_after", busy | done, 0);

    // Reset mid-RUN at cycle 4.
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_d", d, 0);
    chk("mrst_bout", bout, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    chk("mrst_no_done", extra, 0);
    run_op("post_rst", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    run_op("ovf1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    chk("ovf1_ovf", ovf, 1);
    run_op("ovf2", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    chk("ovf2_ovf", ovf, 0);
    run_op("ovf3", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1);
    chk("ovf3_ovf", ovf, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
